// File: rtl/ahb_cmd_manager_if.sv
// Bundle of command, response and AHB-Lite manager signals around ahb_cmd_manager.
// Latency: none; plain wires grouped for port convenience.
// Backpressure: carried by cmd_ready/rsp_ready and hready; the interface itself adds none.
interface ahb_cmd_manager_if #(
    parameter int AddressWidth = 32,
    parameter int DataWidth    = 32
);
    // command channel
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_write;
    logic [AddressWidth-1:0] cmd_addr;
    logic [2:0]              cmd_size;
    logic [DataWidth-1:0]    cmd_wdata;

    // response channel
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DataWidth-1:0]    rsp_rdata;
    logic                    rsp_error;

    // AHB-Lite manager side
    logic [AddressWidth-1:0] haddr;
    logic [1:0]              htrans;
    logic [2:0]              hsize;
    logic                    hwrite;
    logic [2:0]              hburst;
    logic [3:0]              hprot;
    logic [DataWidth-1:0]    hwdata;
    logic [DataWidth-1:0]    hrdata;
    logic                    hready;
    logic                    hresp;

    // view from the command manager itself
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_error,
        input  rsp_ready,
        output haddr, htrans, hsize, hwrite, hburst, hprot, hwdata,
        input  hrdata, hready, hresp
    );

    // view from the command source / AHB subordinate environment
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_error,
        output rsp_ready,
        input  haddr, htrans, hsize, hwrite, hburst, hprot, hwdata,
        output hrdata, hready, hresp
    );
endinterface

// File: rtl/ahb_cmd_manager.sv
// Turns single commands into one AHB-Lite NONSEQ SINGLE transfer each and returns a response.
// Latency: accept at edge N, address phase N..N+1, data phase N+1..N+2, rsp_valid from N+2 plus wait states.
// Backpressure: cmd_ready only in IDLE; response held until rsp_ready; hready stretches both AHB phases.
// Optional macro AHB_CMD_MANAGER_STATS_EN adds saturating transfer/error counters.
module ahb_cmd_manager #(
    parameter int AddressWidth = 32,
    parameter int DataWidth    = 32
) (
    input  logic                hclk,
    input  logic                hresetn,
    ahb_cmd_manager_if.master   bus
`ifdef AHB_CMD_MANAGER_STATS_EN
    ,
    output logic [31:0]         stat_xfer_count,
    output logic [15:0]         stat_err_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    // largest HSIZE that fits the data bus: word for 32-bit, doubleword for 64-bit
    localparam logic [2:0] MAX_SIZE      = (DataWidth == 64) ? 3'd3 : 3'd2;

    state_t                  r_state;
    logic                    r_cmd_ready;
    logic [1:0]              r_htrans;
    logic [AddressWidth-1:0] r_haddr;
    logic [2:0]              r_hsize;
    logic                    r_hwrite;
    logic [DataWidth-1:0]    r_hwdata;
    logic                    r_rsp_valid;
    logic [DataWidth-1:0]    r_rsp_rdata;
    logic                    r_rsp_error;

    logic                    w_cmd_fire;
    logic [2:0]              w_lane_mask;
    logic                    w_size_ok;
    logic                    w_misaligned;
    logic                    w_cmd_bad;

    assign w_cmd_fire = (r_state == S_IDLE) && r_cmd_ready && bus.cmd_valid;

    // low address bits that must be zero for the requested transfer size
    always_comb begin
        w_lane_mask = 3'b111;
        case (bus.cmd_size)
            3'd0:    w_lane_mask = 3'b000;
            3'd1:    w_lane_mask = 3'b001;
            3'd2:    w_lane_mask = 3'b011;
            3'd3:    w_lane_mask = 3'b111;
            default: w_lane_mask = 3'b111;
        endcase
    end

    // oversize transfers are rejected before alignment is even considered
    assign w_size_ok    = (bus.cmd_size <= MAX_SIZE);
    assign w_misaligned = |(bus.cmd_addr[2:0] & w_lane_mask);
    assign w_cmd_bad    = !w_size_ok || w_misaligned;

    // transfer sequencer: every bus-visible output is registered here
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_htrans    <= HTRANS_IDLE;
            r_haddr     <= '0;
            r_hsize     <= 3'd0;
            r_hwrite    <= 1'b0;
            r_hwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_fire) begin
                        r_cmd_ready <= 1'b0;
                        if (w_cmd_bad) begin
                            // illegal command never reaches the bus; answer with an error at once
                            r_rsp_valid <= 1'b1;
                            r_rsp_error <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_state     <= S_RESP;
                        end else begin
                            r_htrans <= HTRANS_NONSEQ;
                            r_haddr  <= bus.cmd_addr;
                            r_hsize  <= bus.cmd_size;
                            r_hwrite <= bus.cmd_write;
                            if (bus.cmd_write) begin
                                r_hwdata <= bus.cmd_wdata;
                            end
                            r_state  <= S_ADDR;
                        end
                    end else begin
                        // first edge out of reset, or simply waiting for a command
                        r_cmd_ready <= 1'b1;
                    end
                end
                S_ADDR: begin
                    if (bus.hready) begin
                        r_htrans <= HTRANS_IDLE;
                        r_state  <= S_DATA;
                    end
                end
                S_DATA: begin
                    // hresp alone (first cycle of a two-cycle error) does not end the phase
                    if (bus.hready) begin
                        r_rsp_rdata <= r_hwrite ? '0 : bus.hrdata;
                        r_rsp_error <= bus.hresp;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_error = r_rsp_error;
    assign bus.haddr     = r_haddr;
    assign bus.htrans    = r_htrans;
    assign bus.hsize     = r_hsize;
    assign bus.hwrite    = r_hwrite;
    assign bus.hwdata    = r_hwdata;
    assign bus.hburst    = 3'b000;
    assign bus.hprot     = 4'b0011;

`ifdef AHB_CMD_MANAGER_STATS_EN
    logic        w_bad_fire;
    logic        w_resp_entry;
    logic        w_resp_err;
    logic [31:0] r_stat_xfer_count;
    logic [15:0] r_stat_err_count;

    assign w_bad_fire   = w_cmd_fire && w_cmd_bad;
    assign w_resp_entry = w_bad_fire || ((r_state == S_DATA) && bus.hready);
    assign w_resp_err   = w_bad_fire || ((r_state == S_DATA) && bus.hready && bus.hresp);

    // saturating counters, stepped on every entry into the response state
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_stat_xfer_count <= '0;
            r_stat_err_count  <= '0;
        end else begin
            if (w_resp_entry && (r_stat_xfer_count != '1)) begin
                r_stat_xfer_count <= r_stat_xfer_count + 32'd1;
            end
            if (w_resp_err && (r_stat_err_count != '1)) begin
                r_stat_err_count <= r_stat_err_count + 16'd1;
            end
        end
    end

    assign stat_xfer_count = r_stat_xfer_count;
    assign stat_err_count  = r_stat_err_count;
`endif

endmodule

// File: doc/ahb_cmd_manager.md
AHB_CMD_MANAGER -- requirements
Module: ahb_cmd_manager

Interface
REQ-001 SHALL have parameter AddressWidth, default 32, meaning haddr/cmd_addr width.
REQ-002 SHALL have parameter DataWidth, default 32, meaning hwdata/hrdata/cmd_wdata/rsp_rdata width; legal values are 32 and 64.
REQ-003 SHALL have ports, one per line: name  direction  width  meaning.
- hclk  in  1  sole clock; all logic rising-edge.
- hresetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  AddressWidth  byte address.
- cmd_size  in  3  AHB HSIZE encoding.
- cmd_wdata  in  DataWidth  write data, already lane-aligned.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready.
- rsp_rdata  out  DataWidth  captured hrdata; 0 for writes.
- rsp_error  out  1  transfer failed.
- haddr  out  AddressWidth; htrans  out  2; hsize  out  3; hwrite  out  1; hburst  out  3 (constant SINGLE=0); hprot  out  4 (constant 4'b0011); hwdata  out  DataWidth.
- hrdata  in  DataWidth; hready  in  1; hresp  in  1 (0=Okay, 1=Error).

Function
REQ-004 SHALL implement FSM states IDLE, ADDR, DATA, RESP; one outstanding transfer, single NONSEQ transfers only, no pipelining.
REQ-005 cmd_ready SHALL be 1 only in IDLE.
REQ-006 On acceptance in IDLE at edge N, SHALL register write/addr/size/wdata and enter ADDR, with htrans=NONSEQ (2'b10) and haddr/hsize/hwrite driven from N.
REQ-007 ADDR: SHALL hold address-phase signals stable until the edge where hready=1, then enter DATA with htrans=IDLE (2'b00).
REQ-008 DATA: SHALL drive hwdata from the registered write data for the whole phase; on the edge where hready=1, SHALL capture hrdata (reads only), set rsp_error=hresp, and enter RESP.
REQ-009 SHALL treat a two-cycle Error response correctly: hresp=1 with hready=0 does not end the phase; the error is taken on the hready=1 cycle.
REQ-010 Minimum latency with zero-wait subordinate: accept at N, NONSEQ at N..N+1, data phase N+1..N+2, rsp_valid=1 from N+2.
REQ-011 RESP: rsp_valid=1 with stable rsp_rdata/rsp_error until rsp_ready=1, then enter IDLE; cmd_ready SHALL rise the cycle after.
REQ-012 Invalid command: if 8<<cmd_size exceeds DataWidth or cmd_addr is not aligned to 2^cmd_size, the block SHALL skip ADDR/DATA, enter RESP directly with rsp_error=1 and rsp_rdata=0, and issue no htrans=NONSEQ.
REQ-013 htrans SHALL be IDLE in every state except ADDR; BUSY and SEQ SHALL never be driven.
REQ-014 haddr/hsize/hwrite SHALL hold their last value outside ADDR.

Reset
REQ-015 hresetn low SHALL asynchronously force state IDLE, htrans=0, haddr=0, hsize=0, hwrite=0, hwdata=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, cmd_ready=0.
REQ-016 cmd_ready SHALL rise on the first hclk edge after hresetn deasserts.
REQ-017 Reset mid-transfer SHALL discard the in-flight command with no response generated.

Configuration
REQ-018 Macro AHB_CMD_MANAGER_STATS_EN defined: SHALL add outputs stat_xfer_count (32, increments per RESP entry) and stat_err_count (16, increments per RESP entry with rsp_error=1), both saturating, reset to 0.
REQ-019 Macro AHB_CMD_MANAGER_STATS_EN undefined: those ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-020 Write addr 'h100, size 2, wdata 'hDEADBEEF, hready always 1 -> one NONSEQ cycle with haddr='h100, hwrite=1; hwdata='hDEADBEEF next cycle; rsp_valid at N+2 with rsp_error=0.
REQ-021 Read 'h204, size 2, subordinate inserts 3 wait states, hrdata='h12345678 -> rsp_rdata='h12345678, rsp_valid 3 cycles later than REQ-010 timing.
REQ-022 Read with two-cycle Error response (hresp=1/hready=0, then hresp=1/hready=1) -> rsp_error=1, no second NONSEQ issued.
REQ-023 Read addr 'h102 size 2 (misaligned), and size 3 with DataWidth 32 -> rsp_error=1, htrans never NONSEQ.
REQ-024 rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_rdata stable, cmd_ready=0; hresetn pulsed during DATA -> all outputs at reset values, no response.
REQ-025 With AHB_CMD_MANAGER_STATS_EN: 3 good and 2 errored transfers -> stat_xfer_count=5, stat_err_count=2.
